// File: rtl/burst_rd_ctrl_if.sv
// Avalon-MM read bus between the burst read engine (master) and memory (slave).
interface burst_rd_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, burstcount,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/burst_rd_ctrl.sv
// Avalon-MM burst read engine: fetches a packet in bounded bursts and writes every
// returned word into the downstream packet FIFO, issuing a burst only when it fits.
module burst_rd_ctrl #(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_ctrl,
  input  logic [31:0]        pkt_begin,
  input  logic [31:0]        pkt_end,
  input  logic [31:0]        read_address,
  output logic               rd_ctrl_rdy,
  output logic               busy,
  output logic [31:0]        fifo_in,
  output logic               wr_to_fifo,
  input  logic [USEDW_W-1:0] fifo_usedw,
  burst_rd_ctrl_if.master    avm
);
  localparam int              CW          = USEDW_W + 9;
  localparam logic [31:0]     MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [CW-1:0]   DEPTH_W     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_cur_addr;
  logic [31:0] r_remaining;
  logic [15:0] r_beats_left;
  logic        r_read;
  logic [31:0] r_address;
  logic [15:0] r_burstcount;
  logic [31:0] r_fifo_in;
  logic        r_wr_to_fifo;
  logic        r_rd_ctrl_rdy;
  logic        r_busy;

  logic [31:0]   w_len;
  logic [15:0]   w_burst;
  logic [CW-1:0] w_credit_sum;
  logic          w_credit_ok;

  assign w_len   = (pkt_end > pkt_begin) ? ((pkt_end - pkt_begin) >> 2) : 32'd0;
  assign w_burst = (r_remaining < MAX_BURST_W) ? r_remaining[15:0] : MAX_BURST_W[15:0];

  // A write strobe already on the wire is not yet visible in fifo_usedw, so count it too.
  assign w_credit_sum = CW'(fifo_usedw) + CW'(r_wr_to_fifo) + CW'(w_burst);
  assign w_credit_ok  = (w_credit_sum <= DEPTH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cur_addr    <= 32'd0;
      r_remaining   <= 32'd0;
      r_beats_left  <= 16'd0;
      r_read        <= 1'b0;
      r_address     <= 32'd0;
      r_burstcount  <= 16'd0;
      r_fifo_in     <= 32'd0;
      r_wr_to_fifo  <= 1'b0;
      r_rd_ctrl_rdy <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_wr_to_fifo  <= 1'b0;
      r_rd_ctrl_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rd_ctrl) begin
            r_cur_addr  <= read_address;
            r_remaining <= w_len;
            r_busy      <= 1'b1;
            if (w_len == 32'd0) begin
              r_state       <= DONE;
              r_rd_ctrl_rdy <= 1'b1;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (!r_read) begin
            if (w_credit_ok) begin
              r_read       <= 1'b1;
              r_address    <= r_cur_addr;
              r_burstcount <= w_burst;
            end
          end else if (!avm.waitrequest) begin
            // Accepted: the latched burstcount is the burst that is now in flight.
            r_read       <= 1'b0;
            r_beats_left <= r_burstcount;
            r_cur_addr   <= r_cur_addr + {14'd0, r_burstcount, 2'b00};
            r_remaining  <= r_remaining - {16'd0, r_burstcount};
            r_state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (avm.readdatavalid) begin
            r_fifo_in    <= avm.readdata;
            r_wr_to_fifo <= 1'b1;
            r_beats_left <= r_beats_left - 16'd1;
            if (r_beats_left == 16'd1) begin
              if (r_remaining == 32'd0) begin
                r_state       <= DONE;
                r_rd_ctrl_rdy <= 1'b1;
              end else begin
                r_state <= REQ;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign avm.read       = r_read;
  assign avm.address    = r_address;
  assign avm.burstcount = r_burstcount;
  assign fifo_in        = r_fifo_in;
  assign wr_to_fifo     = r_wr_to_fifo;
  assign rd_ctrl_rdy    = r_rd_ctrl_rdy;
  assign busy           = r_busy;
endmodule
